// File: rtl/csi_rx_link_ctrl.sv
// csi_rx_link_ctrl
// Link sequencer for the CSI-2 receive datapath. It holds the aligners and the
// packet handler in reset, waits for a run of LP idle, arms reception, and then
// supervises the stream. Loss of FS or a stalled packet stream triggers a
// one-cycle resync followed by a fresh reset hold.
//
// Optional build macro: CSI_RX_LINE_CHECK_EN
//   When defined, a frame whose line count differs from EXP_LINES raises
//   err_lines and forces a resync. When undefined, err_lines is tied low.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RESET_HOLD| datapath held in reset for RST_CYCLES cycles
// ST_WAIT_LP   | datapath released, waiting for LP_MIN consecutive LP cycles
// ST_WAIT_FS   | datapath enabled, waiting for a frame start (FS timeout)
// ST_STREAMING | link up, counting lines/frames, packet watchdog running
// ST_RESYNC    | single cycle, datapath back in reset, resync counted

module csi_rx_link_ctrl #(
   parameter int unsigned RST_CYCLES  = 16,
   parameter int unsigned LP_MIN      = 8,
   parameter logic [23:0] FS_TIMEOUT  = 24'hFFFFFF,
   parameter logic [23:0] PKT_TIMEOUT = 24'h00FFFF,
   parameter logic [15:0] EXP_LINES   = 16'd1080
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        lp_detect,
   input  logic        packet_done,
   input  logic        vsync,
   input  logic        in_frame,
   input  logic        in_line,
   output logic        rx_reset,
   output logic        rx_enable,
   output logic        link_up,
   output logic [15:0] frame_count,
   output logic [15:0] last_frame_lines,
   output logic [7:0]  resync_count,
   output logic        err_timeout,
   output logic        err_lines
);

   typedef enum logic [2:0] {
      ST_RESET_HOLD = 3'd0,
      ST_WAIT_LP    = 3'd1,
      ST_WAIT_FS    = 3'd2,
      ST_STREAMING  = 3'd3,
      ST_RESYNC     = 3'd4
   } state_t;

   localparam logic [15:0] HOLD_LAST = 16'(RST_CYCLES - 1);
   localparam logic [15:0] LP_LAST   = 16'(LP_MIN - 1);
   localparam logic [23:0] FS_LAST   = FS_TIMEOUT - 24'd1;
   localparam logic [23:0] PKT_LAST  = PKT_TIMEOUT - 24'd1;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] hold_cnt;
   logic [15:0] lp_run;
   logic [23:0] timer;
   logic [15:0] line_cnt;
   logic        in_line_q;
   logic        in_frame_q;
   logic        line_rise;
   logic        frame_fall;
   logic        pkt_activity;
   logic        timeout_hit;
   logic        line_err;

   assign line_rise    = in_line & ~in_line_q;
   assign frame_fall   = in_frame_q & ~in_frame;
   assign pkt_activity = packet_done | lp_detect;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_RESET_HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and Moore outputs; line-check error outranks the watchdog.
   always_comb begin
      state_nxt   = state;
      rx_reset    = 1'b0;
      rx_enable   = 1'b0;
      link_up     = 1'b0;
      timeout_hit = 1'b0;
      line_err    = 1'b0;
      case (state)
         ST_RESET_HOLD: begin
            rx_reset = 1'b1;
            if (hold_cnt == HOLD_LAST) begin
               state_nxt = ST_WAIT_LP;
            end
         end
         ST_WAIT_LP: begin
            if (lp_detect && (lp_run == LP_LAST)) begin
               state_nxt = ST_WAIT_FS;
            end
         end
         ST_WAIT_FS: begin
            rx_enable = 1'b1;
            if (vsync) begin
               state_nxt = ST_STREAMING;
            end else if (timer == FS_LAST) begin
               state_nxt   = ST_RESYNC;
               timeout_hit = 1'b1;
            end
         end
         ST_STREAMING: begin
            rx_enable = 1'b1;
            link_up   = 1'b1;
`ifdef CSI_RX_LINE_CHECK_EN
            line_err  = frame_fall && (line_cnt != EXP_LINES);
`endif
            if (line_err) begin
               state_nxt = ST_RESYNC;
            end else if (!pkt_activity && (timer == PKT_LAST)) begin
               state_nxt   = ST_RESYNC;
               timeout_hit = 1'b1;
            end
         end
         ST_RESYNC: begin
            rx_reset  = 1'b1;
            state_nxt = ST_RESET_HOLD;
         end
         default: begin
            rx_reset  = 1'b1;
            state_nxt = ST_RESET_HOLD;
         end
      endcase
   end

   // Reset-hold length counter, restarts on every entry into RESET_HOLD.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if ((state == ST_RESET_HOLD) && (state_nxt == ST_RESET_HOLD)) begin
         hold_cnt <= hold_cnt + 16'd1;
      end else begin
         hold_cnt <= '0;
      end
   end

   // Consecutive LP-idle run; any non-LP cycle restarts the run.
   always_ff @(posedge clock) begin
      if (reset) begin
         lp_run <= '0;
      end else if ((state == ST_WAIT_LP) && lp_detect && (state_nxt == ST_WAIT_LP)) begin
         lp_run <= lp_run + 16'd1;
      end else begin
         lp_run <= '0;
      end
   end

   // Shared timer: FS wait timer in WAIT_FS, packet watchdog in STREAMING.
   always_ff @(posedge clock) begin
      if (reset) begin
         timer <= '0;
      end else begin
         case (state)
            ST_WAIT_FS: begin
               if (state_nxt != ST_WAIT_FS) begin
                  timer <= '0;
               end else begin
                  timer <= timer + 24'd1;
               end
            end
            ST_STREAMING: begin
               if (pkt_activity || (state_nxt != ST_STREAMING)) begin
                  timer <= '0;
               end else begin
                  timer <= timer + 24'd1;
               end
            end
            default: timer <= '0;
         endcase
      end
   end

   // Previous-cycle copies of the frame/line levels for edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_line_q  <= 1'b0;
         in_frame_q <= 1'b0;
      end else begin
         in_line_q  <= in_line;
         in_frame_q <= in_frame;
      end
   end

   // Line counter: cleared by FS, bumped on each new long packet, saturating.
   always_ff @(posedge clock) begin
      if (reset) begin
         line_cnt <= '0;
      end else if (((state == ST_WAIT_FS) || (state == ST_STREAMING)) && vsync) begin
         line_cnt <= '0;
      end else if ((state == ST_STREAMING) && line_rise && (line_cnt != 16'hFFFF)) begin
         line_cnt <= line_cnt + 16'd1;
      end
   end

   // Frame statistics; these survive a resync and only reset clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_count      <= '0;
         last_frame_lines <= '0;
      end else begin
         if (((state == ST_WAIT_FS) || (state == ST_STREAMING)) && vsync) begin
            frame_count <= frame_count + 16'd1;
         end
         if ((state == ST_STREAMING) && frame_fall) begin
            last_frame_lines <= line_cnt;
         end
      end
   end

   // Saturating resync counter, bumped once per RESYNC cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         resync_count <= '0;
      end else if ((state == ST_RESYNC) && (resync_count != 8'hFF)) begin
         resync_count <= resync_count + 8'd1;
      end
   end

   // Error pulses registered so they line up with the RESYNC cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= timeout_hit;
      end
   end

`ifdef CSI_RX_LINE_CHECK_EN
   // Line-count mismatch pulse, aligned with the RESYNC cycle it causes.
   always_ff @(posedge clock) begin
      if (reset) begin
         err_lines <= 1'b0;
      end else begin
         err_lines <= line_err;
      end
   end
`else
   logic unused_exp_lines;
   assign unused_exp_lines = ^{EXP_LINES, line_err};
   assign err_lines        = 1'b0;
`endif

endmodule
